// File: rtl/ghost_status_tracker_pkg.sv
// ghost_status_tracker_pkg
// Shared definitions for the ghost life-state tracker and the ghost movement
// controllers:
//   - ghost_dead codes consumed by every ghost controller
//   - tracker FSM state encoding
//   - default home tile that the eyes return to
//   - award base value and the award helper function
package ghost_status_tracker_pkg;

    // ghost_dead codes; code 3 is never driven
    localparam logic [1:0] GHOST_ALIVE   = 2'd0;
    localparam logic [1:0] GHOST_EYES    = 2'd1;
    localparam logic [1:0] GHOST_REVIVED = 2'd2;

    typedef enum logic [2:0] {
        ST_ALIVE     = 3'd0,
        ST_EATEN     = 3'd1,
        ST_RETURNING = 3'd2,
        ST_REVIVED   = 3'd3,
        ST_CAUGHT    = 3'd4
    } tracker_state_t;

    localparam int unsigned HOME_H_DEFAULT = 14;
    localparam int unsigned HOME_V_DEFAULT = 12;

    localparam logic [10:0] AWARD_BASE = 11'd200;

    // 200 / 400 / 800 / 1600 for the 1st..4th ghost of one energizer period
    function automatic logic [10:0] award_value(input logic [1:0] chain_idx);
        return AWARD_BASE << chain_idx;
    endfunction

    // Colour/behaviour code reported to the ghost controller for a state
    function automatic logic [1:0] ghost_dead_code(input tracker_state_t st);
        logic [1:0] code;
        case (st)
            ST_EATEN, ST_RETURNING: code = GHOST_EYES;
            ST_REVIVED:             code = GHOST_REVIVED;
            default:                code = GHOST_ALIVE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/ghost_status_tracker_if.sv
// ghost_status_tracker_if
// Bundle between the game core and one ghost status tracker.
//   Frame/control : vsync_enable, pause, end_of_game
//   Positions     : h/v_ghost_tile, h/v_pacman_tile (5 bits each)
//   Energizer     : scared_mode (level), scared_start (pulse), chain_idx
//   Status out    : ghost_dead[1:0], pacman_dead, stall
//   Score out     : score_valid (pulse), score_add[10:0]
// master = game core side, slave = tracker side.
interface ghost_status_tracker_if;
    logic        vsync_enable;
    logic        pause;
    logic        end_of_game;
    logic [4:0]  h_ghost_tile;
    logic [4:0]  v_ghost_tile;
    logic [4:0]  h_pacman_tile;
    logic [4:0]  v_pacman_tile;
    logic        scared_mode;
    logic        scared_start;
    logic [1:0]  chain_idx;
    logic [1:0]  ghost_dead;
    logic        pacman_dead;
    logic        stall;
    logic        score_valid;
    logic [10:0] score_add;

    modport master (
        output vsync_enable, pause, end_of_game,
        output h_ghost_tile, v_ghost_tile, h_pacman_tile, v_pacman_tile,
        output scared_mode, scared_start, chain_idx,
        input  ghost_dead, pacman_dead, stall, score_valid, score_add
    );

    modport slave (
        input  vsync_enable, pause, end_of_game,
        input  h_ghost_tile, v_ghost_tile, h_pacman_tile, v_pacman_tile,
        input  scared_mode, scared_start, chain_idx,
        output ghost_dead, pacman_dead, stall, score_valid, score_add
    );
endinterface

// File: rtl/ghost_frame_timer.sv
// ghost_frame_timer
// 7-bit frame countdown shared by the EATEN and CAUGHT states.
//   clk, reset (async, active low)
//   vsync_enable : frame pulse; counted only while pause is low
//   pause        : freezes the count
//   clear        : synchronous clear to zero (highest after reset)
//   load         : load load_value (a value N expires on the Nth counted frame)
//   done         : combinational, high on the frame pulse that expires the count
module ghost_frame_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync_enable,
    input  logic       pause,
    input  logic       clear,
    input  logic       load,
    input  logic [6:0] load_value,
    output logic       done
);
    logic [6:0] count_reg;
    logic [6:0] count_next;
    logic       tick;

    always_comb begin
        tick       = vsync_enable & ~pause;
        // Expire on the pulse that would take the count from 1 to 0, so the
        // owner can change state on that same edge.
        done       = tick && (count_reg == 7'd1);
        count_next = count_reg;
        if (clear) begin
            count_next = 7'd0;
        end else if (load) begin
            count_next = load_value;
        end else if (tick && (count_reg != 7'd0)) begin
            count_next = count_reg - 7'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_reg <= 7'd0;
        end else begin
            count_reg <= count_next;
        end
    end
endmodule

// File: rtl/ghost_status_tracker.sv
// ghost_status_tracker
// Per-ghost life state and collision resolver. Compares ghost and Pac-Man
// tiles, decides who is eaten from scared_mode, sequences the ghost through
// eaten / returning / revived, and issues the score award for an eaten ghost.
//   clk, reset (async, active low)
//   bus : ghost_status_tracker_if.slave (inputs: frame/control, tiles,
//         energizer; outputs: ghost_dead, pacman_dead, stall, score_valid,
//         score_add). All outputs are registered.
module ghost_status_tracker
    import ghost_status_tracker_pkg::*;
#(
    parameter int unsigned EAT_FRAMES   = 30,
    parameter int unsigned DEATH_FRAMES = 90,
    parameter int unsigned HOME_H       = HOME_H_DEFAULT,
    parameter int unsigned HOME_V       = HOME_V_DEFAULT
) (
    input logic                   clk,
    input logic                   reset,
    ghost_status_tracker_if.slave bus
);
    tracker_state_t state_reg, state_next;

    logic        hit;
    logic        at_home;
    logic        award;
    logic        timer_load;
    logic [6:0]  timer_load_value;
    logic        timer_done;

    logic [1:0]  ghost_dead_reg, ghost_dead_next;
    logic        pacman_dead_reg, pacman_dead_next;
    logic        stall_reg, stall_next;
    logic        score_valid_reg, score_valid_next;
    logic [10:0] score_add_reg, score_add_next;

    ghost_frame_timer u_frame_timer (
        .clk          (clk),
        .reset        (reset),
        .vsync_enable (bus.vsync_enable),
        .pause        (bus.pause),
        .clear        (bus.end_of_game),
        .load         (timer_load),
        .load_value   (timer_load_value),
        .done         (timer_done)
    );

    always_comb begin
        hit     = (bus.h_ghost_tile == bus.h_pacman_tile) &&
                  (bus.v_ghost_tile == bus.v_pacman_tile);
        at_home = (bus.h_ghost_tile == 5'(HOME_H)) &&
                  (bus.v_ghost_tile == 5'(HOME_V));

        state_next       = state_reg;
        award            = 1'b0;
        timer_load       = 1'b0;
        timer_load_value = 7'(EAT_FRAMES);

        if (bus.end_of_game) begin
            state_next = ST_ALIVE;
        end else if (!bus.pause) begin
            case (state_reg)
                ST_ALIVE: begin
                    if (hit) begin
                        timer_load = 1'b1;
                        if (bus.scared_mode) begin
                            state_next = ST_EATEN;
                            award      = 1'b1;
                        end else begin
                            state_next       = ST_CAUGHT;
                            timer_load_value = 7'(DEATH_FRAMES);
                        end
                    end
                end
                ST_EATEN: begin
                    if (timer_done) state_next = ST_RETURNING;
                end
                ST_RETURNING: begin
                    // Eyes cannot collide; only home arrival matters.
                    if (at_home) state_next = bus.scared_mode ? ST_REVIVED : ST_ALIVE;
                end
                ST_REVIVED: begin
                    if (hit) begin
                        state_next       = ST_CAUGHT;
                        timer_load       = 1'b1;
                        timer_load_value = 7'(DEATH_FRAMES);
                    end else if (!bus.scared_mode || bus.scared_start) begin
                        // scared_mode can only be low here after it has fallen,
                        // since REVIVED is entered with scared_mode high.
                        state_next = ST_ALIVE;
                    end
                end
                ST_CAUGHT: begin
                    if (timer_done) state_next = ST_ALIVE;
                end
                default: state_next = ST_ALIVE;
            endcase
        end

        ghost_dead_next  = ghost_dead_code(state_next);
        pacman_dead_next = (state_next == ST_CAUGHT);
        stall_next       = (state_next == ST_EATEN);
        score_valid_next = award;
        if (award) begin
            score_add_next = award_value(bus.chain_idx);
        end else if (bus.end_of_game) begin
            score_add_next = 11'd0;
        end else begin
            score_add_next = score_add_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= ST_ALIVE;
            ghost_dead_reg  <= GHOST_ALIVE;
            pacman_dead_reg <= 1'b0;
            stall_reg       <= 1'b0;
            score_valid_reg <= 1'b0;
            score_add_reg   <= 11'd0;
        end else begin
            state_reg       <= state_next;
            ghost_dead_reg  <= ghost_dead_next;
            pacman_dead_reg <= pacman_dead_next;
            stall_reg       <= stall_next;
            score_valid_reg <= score_valid_next;
            score_add_reg   <= score_add_next;
        end
    end

    assign bus.ghost_dead  = ghost_dead_reg;
    assign bus.pacman_dead = pacman_dead_reg;
    assign bus.stall       = stall_reg;
    assign bus.score_valid = score_valid_reg;
    assign bus.score_add   = score_add_reg;
endmodule

// File: tb/tb_ghost_status_tracker.sv
// tb_ghost_status_tracker
// Self-checking bench for ghost_status_tracker. Score awards are predicted
// into a queue when the eating collision is driven and popped by a monitor
// whenever score_valid is seen; state/output checks are made inline.
module tb_ghost_status_tracker;
    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ghost_status_tracker_if bus ();

    ghost_status_tracker #(
        .EAT_FRAMES   (30),
        .DEATH_FRAMES (90),
        .HOME_H       (14),
        .HOME_V       (12)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    logic [10:0] award_q [$];

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end else begin
            $display("ok   %s: %0d", tag, observed);
        end
    endtask

    // Award monitor: each score_valid cycle must match one predicted award.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.score_valid === 1'b1) begin
            if (award_q.size() == 0)
                check_value("award_unexpected", 32'(award_q.size()), 32'd1);
            else
                check_value("award_value", 32'(bus.score_add), 32'(award_q.pop_front()));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        bus.vsync_enable = 1'b1;
        step();
        bus.vsync_enable = 1'b0;
        step();
    endtask

    task automatic set_tiles(input logic [4:0] gh, input logic [4:0] gv,
                             input logic [4:0] ph, input logic [4:0] pv);
        bus.h_ghost_tile  = gh;
        bus.v_ghost_tile  = gv;
        bus.h_pacman_tile = ph;
        bus.v_pacman_tile = pv;
    endtask

    // Frames until the watched output drops; bounded at 200 frames.
    task automatic count_frames(input bit watch_dead, output int n);
        n = 0;
        while ((watch_dead ? bus.pacman_dead : bus.stall) === 1'b1 && n < 200) begin
            frame();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset            = 1'b0;
        bus.vsync_enable = 1'b0;
        bus.pause        = 1'b0;
        bus.end_of_game  = 1'b0;
        bus.scared_mode  = 1'b0;
        bus.scared_start = 1'b0;
        bus.chain_idx    = 2'd0;
        set_tiles(5'd0, 5'd0, 5'd3, 5'd3);
        repeat (3) step();

        check_value("rst_ghost_dead",  32'(bus.ghost_dead), 32'd0);
        check_value("rst_pacman_dead", 32'(bus.pacman_dead), 32'd0);
        check_value("rst_stall",       32'(bus.stall), 32'd0);
        check_value("rst_score_valid", 32'(bus.score_valid), 32'd0);
        check_value("rst_score_add",   32'(bus.score_add), 32'd0);
        reset = 1'b1;
        step();

        // Scared collision, third ghost of the chain: 800 points, 30-frame stall
        bus.scared_mode = 1'b1;
        bus.chain_idx   = 2'd2;
        award_q.push_back(11'd800);
        set_tiles(5'd5, 5'd5, 5'd5, 5'd5);
        step();
        check_value("eaten_ghost_dead", 32'(bus.ghost_dead), 32'd1);
        check_value("eaten_stall",      32'(bus.stall), 32'd1);
        set_tiles(5'd5, 5'd5, 5'd1, 5'd1);
        count_frames(1'b0, n);
        check_value("eat_stall_frames", 32'(n), 32'd30);
        check_value("returning_ghost_dead", 32'(bus.ghost_dead), 32'd1);
        check_value("score_add_held",       32'(bus.score_add), 32'd800);

        // Eyes reach home while scared -> revived; revived ghost is lethal
        set_tiles(5'd14, 5'd12, 5'd1, 5'd1);
        step();
        check_value("revived_ghost_dead", 32'(bus.ghost_dead), 32'd2);
        set_tiles(5'd14, 5'd12, 5'd14, 5'd12);
        step();
        check_value("revived_hit_pacman_dead", 32'(bus.pacman_dead), 32'd1);
        set_tiles(5'd14, 5'd12, 5'd1, 5'd1);
        count_frames(1'b1, n);
        check_value("death_frames_revived", 32'(n), 32'd90);
        check_value("after_death_ghost_dead", 32'(bus.ghost_dead), 32'd0);

        // Unscared collision: Pac-Man caught, no award
        bus.scared_mode = 1'b0;
        set_tiles(5'd14, 5'd12, 5'd14, 5'd12);
        step();
        check_value("caught_pacman_dead", 32'(bus.pacman_dead), 32'd1);
        check_value("caught_no_award",    32'(bus.score_valid), 32'd0);
        set_tiles(5'd14, 5'd12, 5'd1, 5'd1);
        count_frames(1'b1, n);
        check_value("death_frames_alive", 32'(n), 32'd90);

        // Collision while paused is not evaluated
        bus.scared_mode = 1'b1;
        bus.pause       = 1'b1;
        set_tiles(5'd14, 5'd12, 5'd14, 5'd12);
        repeat (2) step();
        check_value("pause_no_eat_stall", 32'(bus.stall), 32'd0);
        check_value("pause_no_eat_dead",  32'(bus.ghost_dead), 32'd0);
        set_tiles(5'd14, 5'd12, 5'd1, 5'd1);
        bus.pause = 1'b0;
        step();

        // Pause for 10 frames during EATEN stretches the stall by 10 frames
        bus.chain_idx = 2'd0;
        award_q.push_back(11'd200);
        set_tiles(5'd5, 5'd5, 5'd5, 5'd5);
        step();
        check_value("eaten2_stall", 32'(bus.stall), 32'd1);
        set_tiles(5'd5, 5'd5, 5'd1, 5'd1);
        repeat (5) frame();
        bus.pause = 1'b1;
        repeat (10) frame();
        check_value("paused_stall",      32'(bus.stall), 32'd1);
        check_value("paused_ghost_dead", 32'(bus.ghost_dead), 32'd1);
        bus.pause = 1'b0;
        count_frames(1'b0, n);
        check_value("stall_total_with_pause", 32'(n + 15), 32'd40);

        // end_of_game in RETURNING clears everything
        check_value("ret2_ghost_dead", 32'(bus.ghost_dead), 32'd1);
        bus.end_of_game = 1'b1;
        step();
        bus.end_of_game = 1'b0;
        check_value("eog_ghost_dead",  32'(bus.ghost_dead), 32'd0);
        check_value("eog_pacman_dead", 32'(bus.pacman_dead), 32'd0);
        check_value("eog_stall",       32'(bus.stall), 32'd0);
        check_value("eog_score_valid", 32'(bus.score_valid), 32'd0);
        check_value("eog_score_add",   32'(bus.score_add), 32'd0);
        bus.scared_mode = 1'b0;
        set_tiles(5'd5, 5'd5, 5'd5, 5'd5);
        step();
        check_value("eog_alive_catches", 32'(bus.pacman_dead), 32'd1);
        set_tiles(5'd5, 5'd5, 5'd1, 5'd1);
        repeat (3) frame();

        // Asynchronous reset mid-CAUGHT, then a fresh first-ghost award
        reset = 1'b0;
        #1;
        check_value("midreset_pacman_dead", 32'(bus.pacman_dead), 32'd0);
        check_value("midreset_ghost_dead",  32'(bus.ghost_dead), 32'd0);
        step();
        reset = 1'b1;
        step();
        bus.scared_mode = 1'b1;
        bus.chain_idx   = 2'd0;
        award_q.push_back(11'd200);
        set_tiles(5'd5, 5'd5, 5'd5, 5'd5);
        step();
        check_value("post_reset_eaten", 32'(bus.ghost_dead), 32'd1);
        set_tiles(5'd5, 5'd5, 5'd1, 5'd1);
        repeat (2) step();

        check_value("award_queue_empty", 32'(award_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
